// File: rtl/hazard_scoreboard_if.sv
// Bundle of ID-stage inputs and pipeline-control outputs for the hazard scoreboard.
// The master side is the ID stage driver; the slave side is the scoreboard itself.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
);
  logic             idValid;
  logic [REG_W-1:0] idRs;
  logic [REG_W-1:0] idRt;
  logic             idUsesRs;
  logic             idUsesRt;
  logic             idRegWrite;
  logic [REG_W-1:0] idRd;
  logic             idMemRead;
  logic             branchFlush;
  logic             memStall;
  logic             pcWrite;
  logic             ifidWrite;
  logic             idexBubble;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output idValid, idRs, idRt, idUsesRs, idUsesRt, idRegWrite, idRd, idMemRead,
           branchFlush, memStall,
    input  pcWrite, ifidWrite, idexBubble, forwardA, forwardB, stallCount
  );

  modport slave (
    input  idValid, idRs, idRt, idUsesRs, idUsesRt, idRegWrite, idRd, idMemRead,
           branchFlush, memStall,
    output pcWrite, ifidWrite, idexBubble, forwardA, forwardB, stallCount
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: shadows the EX/MEM/WB writers, stalls on load-use,
// honours branch flush and memory freeze, and pre-computes registered forward selects
// that are valid while the instruction sits in EX.
module hazard_scoreboard #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic             v;
    logic             rw;
    logic [REG_W-1:0] rd;
    logic             ld;
  } shadow_t;

  shadow_t          e_q, e_d;
  shadow_t          m_q, m_d;
  // The WB shadow is tracked for completeness; the register file writes before it
  // is read, so no ID decision ever needs to look at it.
  shadow_t          unusedWb_q, unusedWb_d;
  logic [1:0]       fwdA_q, fwdA_d;
  logic [1:0]       fwdB_q, fwdB_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic loadUse;
  logic pcWrite;
  logic ifidWrite;
  logic idexBubble;

  function automatic logic hit(input shadow_t s, input logic [REG_W-1:0] r);
    return s.v & s.rw & (s.rd != '0) & (s.rd == r);
  endfunction

  // Load-use detection plus the priority chain memStall > flush > stall > normal.
  always_comb begin
    e_d        = e_q;
    m_d        = m_q;
    unusedWb_d = unusedWb_q;
    fwdA_d     = fwdA_q;
    fwdB_d     = fwdB_q;
    cnt_d      = cnt_q;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexBubble = 1'b0;

    loadUse = bus.idValid & e_q.ld &
              ((bus.idUsesRs & hit(e_q, bus.idRs)) |
               (bus.idUsesRt & hit(e_q, bus.idRt)));

    if (bus.memStall) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end else if (bus.branchFlush) begin
      idexBubble = 1'b1;
      e_d        = '0;
      m_d        = e_q;
      unusedWb_d = m_q;
      fwdA_d     = 2'b00;
      fwdB_d     = 2'b00;
    end else if (loadUse) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      e_d        = '0;
      m_d        = e_q;
      unusedWb_d = m_q;
      fwdA_d     = 2'b00;
      fwdB_d     = 2'b00;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      e_d        = shadow_t'{v: bus.idValid, rw: bus.idRegWrite, rd: bus.idRd, ld: bus.idMemRead};
      m_d        = e_q;
      unusedWb_d = m_q;
      if (bus.idUsesRs && hit(e_q, bus.idRs)) begin
        fwdA_d = 2'b10;
      end else if (bus.idUsesRs && hit(m_q, bus.idRs)) begin
        fwdA_d = 2'b01;
      end else begin
        fwdA_d = 2'b00;
      end
      if (bus.idUsesRt && hit(e_q, bus.idRt)) begin
        fwdB_d = 2'b10;
      end else if (bus.idUsesRt && hit(m_q, bus.idRt)) begin
        fwdB_d = 2'b01;
      end else begin
        fwdB_d = 2'b00;
      end
    end
  end

  // Shadow stages, forward selects and stall counter; reset empties everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q        <= '0;
      m_q        <= '0;
      unusedWb_q <= '0;
      fwdA_q     <= 2'b00;
      fwdB_q     <= 2'b00;
      cnt_q      <= '0;
    end else begin
      e_q        <= e_d;
      m_q        <= m_d;
      unusedWb_q <= unusedWb_d;
      fwdA_q     <= fwdA_d;
      fwdB_q     <= fwdB_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pcWrite    = pcWrite;
  assign bus.ifidWrite  = ifidWrite;
  assign bus.idexBubble = idexBubble;
  assign bus.forwardA   = fwdA_q;
  assign bus.forwardB   = fwdB_q;
  assign bus.stallCount = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard with an instruction-level reference model
// of the pipeline occupants and a few hand-computed literal expectations.
module tb_hazard_scoreboard;
  localparam int TB_CNT_W = 4;
  localparam int TB_REG_W = 5;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.CNT_W(TB_CNT_W), .REG_W(TB_REG_W)) hsIf ();

  hazard_scoreboard #(.CNT_W(TB_CNT_W), .REG_W(TB_REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hsIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instructions currently occupying EX (0), MEM (1) and WB (2).
  typedef struct {
    bit v;
    bit rw;
    int rd;
    bit ld;
  } instT;

  instT pipe [3];
  int   mdlFwdA;
  int   mdlFwdB;
  int   mdlCount;

  int lastPc;
  int lastIfid;
  int lastBubble;

  task automatic compareValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    mdlFwdA  = 0;
    mdlFwdB  = 0;
    mdlCount = 0;
  endtask

  function automatic bit writesReg(input instT ins, input int r);
    return ins.v && ins.rw && (ins.rd != 0) && (ins.rd == r);
  endfunction

  function automatic bit modelLoadUse();
    if (!hsIf.idValid || !pipe[0].ld) return 1'b0;
    return (hsIf.idUsesRs && writesReg(pipe[0], int'(hsIf.idRs))) ||
           (hsIf.idUsesRt && writesReg(pipe[0], int'(hsIf.idRt)));
  endfunction

  // Newest producer wins: the instruction about to move into MEM beats the one into WB.
  function automatic int sourceSelect(input bit uses, input int r);
    if (!uses) return 0;
    if (writesReg(pipe[0], r)) return 2;
    if (writesReg(pipe[1], r)) return 1;
    return 0;
  endfunction

  task automatic modelStep();
    instT incoming;
    bit   lu;
    bit   kill;
    lu = modelLoadUse();
    if (hsIf.memStall) return;
    kill = hsIf.branchFlush || lu;
    if (kill) begin
      incoming = '{0, 0, 0, 0};
      mdlFwdA  = 0;
      mdlFwdB  = 0;
    end else begin
      incoming = '{hsIf.idValid, hsIf.idRegWrite, int'(hsIf.idRd), hsIf.idMemRead};
      mdlFwdA  = sourceSelect(hsIf.idUsesRs, int'(hsIf.idRs));
      mdlFwdB  = sourceSelect(hsIf.idUsesRt, int'(hsIf.idRt));
    end
    if (lu && !hsIf.branchFlush && mdlCount < CNT_MAX) mdlCount++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = incoming;
  endtask

  task automatic checkOutput();
    bit lu;
    int expEnable;
    int expBubble;
    lu        = modelLoadUse();
    expEnable = (!hsIf.memStall && (hsIf.branchFlush || !lu)) ? 1 : 0;
    expBubble = (!hsIf.memStall && (hsIf.branchFlush || lu)) ? 1 : 0;
    compareValue("pcWrite",    int'(hsIf.pcWrite),    expEnable);
    compareValue("ifidWrite",  int'(hsIf.ifidWrite),  expEnable);
    compareValue("idexBubble", int'(hsIf.idexBubble), expBubble);
    compareValue("forwardA",   int'(hsIf.forwardA),   mdlFwdA);
    compareValue("forwardB",   int'(hsIf.forwardB),   mdlFwdB);
    compareValue("stallCount", int'(hsIf.stallCount), mdlCount);
  endtask

  // Drive one ID-stage vector for one cycle, check mid-cycle, then advance the model.
  task automatic applyStimulus(input bit v, input int rs, input int rt, input bit uRs,
                               input bit uRt, input bit rw, input int rd, input bit ld,
                               input bit flush, input bit mst);
    hsIf.idValid     = v;
    hsIf.idRs        = TB_REG_W'(rs);
    hsIf.idRt        = TB_REG_W'(rt);
    hsIf.idUsesRs    = uRs;
    hsIf.idUsesRt    = uRt;
    hsIf.idRegWrite  = rw;
    hsIf.idRd        = TB_REG_W'(rd);
    hsIf.idMemRead   = ld;
    hsIf.branchFlush = flush;
    hsIf.memStall    = mst;
    @(negedge clk);
    lastPc     = int'(hsIf.pcWrite);
    lastIfid   = int'(hsIf.ifidWrite);
    lastBubble = int'(hsIf.idexBubble);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doNop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doLoad(input int rd);
    applyStimulus(1, 0, 0, 1, 0, 1, rd, 1, 0, 0);
  endtask

  task automatic doAlu(input int rd, input int rs, input int rt, input bit flush, input bit mst);
    applyStimulus(1, rs, rt, 1, 1, 1, rd, 0, flush, mst);
  endtask

  task automatic idleInputs();
    hsIf.idValid     = 1'b0;
    hsIf.idRs        = '0;
    hsIf.idRt        = '0;
    hsIf.idUsesRs    = 1'b0;
    hsIf.idUsesRt    = 1'b0;
    hsIf.idRegWrite  = 1'b0;
    hsIf.idRd        = '0;
    hsIf.idMemRead   = 1'b0;
    hsIf.branchFlush = 1'b0;
    hsIf.memStall    = 1'b0;
  endtask

  initial begin
    modelReset();
    rst = 1'b0;
    hsIf.idValid     = 1'b1;
    hsIf.idRs        = TB_REG_W'($urandom_range(31));
    hsIf.idRt        = TB_REG_W'($urandom_range(31));
    hsIf.idUsesRs    = 1'($urandom_range(1));
    hsIf.idUsesRt    = 1'($urandom_range(1));
    hsIf.idRegWrite  = 1'($urandom_range(1));
    hsIf.idRd        = TB_REG_W'($urandom_range(31));
    hsIf.idMemRead   = 1'($urandom_range(1));
    hsIf.branchFlush = 1'b0;
    hsIf.memStall    = 1'b0;
    #12;
    compareValue("rstForwardA",   int'(hsIf.forwardA),   0);
    compareValue("rstForwardB",   int'(hsIf.forwardB),   0);
    compareValue("rstStallCount", int'(hsIf.stallCount), 0);
    compareValue("rstPcWrite",    int'(hsIf.pcWrite),    1);
    compareValue("rstBubble",     int'(hsIf.idexBubble), 0);
    idleInputs();
    #1 rst = 1'b1;
    @(posedge clk);
    modelStep();
    #1;
    repeat (3) doNop();
    compareValue("idleForwardA",   int'(hsIf.forwardA),   0);
    compareValue("idleStallCount", int'(hsIf.stallCount), 0);
    compareValue("idlePcWrite",    lastPc,                1);

    $display("[TB] load-use stall");
    doLoad(8);
    applyStimulus(1, 8, 3, 1, 1, 1, 9, 0, 0, 0);
    compareValue("luPcWrite",    lastPc,                0);
    compareValue("luIfidWrite",  lastIfid,              0);
    compareValue("luBubble",     lastBubble,            1);
    compareValue("luStallCount", int'(hsIf.stallCount), 1);
    applyStimulus(1, 8, 3, 1, 1, 1, 9, 0, 0, 0);
    compareValue("luIssuePc",    lastPc,                1);
    compareValue("luForwardA",   int'(hsIf.forwardA),   1);
    compareValue("luForwardB",   int'(hsIf.forwardB),   0);

    $display("[TB] EX/MEM over MEM/WB");
    repeat (3) doNop();
    doAlu(5, 1, 2, 0, 0);
    doAlu(5, 1, 2, 0, 0);
    doAlu(6, 5, 5, 0, 0);
    compareValue("prioPcWrite", lastPc,              1);
    compareValue("prioFwdA",    int'(hsIf.forwardA), 2);
    compareValue("prioFwdB",    int'(hsIf.forwardB), 2);
    repeat (3) doNop();
    doAlu(5, 1, 2, 0, 0);
    doNop();
    doAlu(6, 5, 5, 0, 0);
    compareValue("memFwdA", int'(hsIf.forwardA), 1);
    compareValue("memFwdB", int'(hsIf.forwardB), 1);

    $display("[TB] zero register and unused operand");
    repeat (3) doNop();
    doLoad(0);
    doAlu(1, 0, 0, 0, 0);
    compareValue("zeroPcWrite", lastPc,     1);
    compareValue("zeroBubble",  lastBubble, 0);
    doLoad(8);
    applyStimulus(1, 1, 8, 1, 0, 1, 10, 0, 0, 0);
    compareValue("noUsePcWrite",    lastPc,                1);
    compareValue("noUseStallCount", int'(hsIf.stallCount), 1);

    $display("[TB] flush over stall");
    repeat (3) doNop();
    doLoad(8);
    doAlu(9, 8, 3, 1, 0);
    compareValue("flushBubble",     lastBubble,            1);
    compareValue("flushPcWrite",    lastPc,                1);
    compareValue("flushStallCount", int'(hsIf.stallCount), 1);
    compareValue("flushForwardA",   int'(hsIf.forwardA),   0);
    doNop();

    $display("[TB] memory freeze during load-use");
    repeat (3) doNop();
    doLoad(8);
    for (int i = 0; i < 3; i++) begin
      doAlu(9, 8, 3, 0, 1);
      compareValue("frzPcWrite", lastPc,     0);
      compareValue("frzBubble",  lastBubble, 0);
    end
    compareValue("frzStallCount", int'(hsIf.stallCount), 1);
    doAlu(9, 8, 3, 0, 0);
    compareValue("relPcWrite",    lastPc,                0);
    compareValue("relBubble",     lastBubble,            1);
    compareValue("relStallCount", int'(hsIf.stallCount), 2);
    doAlu(9, 8, 3, 0, 0);
    compareValue("relIssuePc",  lastPc,              1);
    compareValue("relForwardA", int'(hsIf.forwardA), 1);

    $display("[TB] asynchronous reset mid-stall");
    repeat (3) doNop();
    doLoad(8);
    hsIf.idValid    = 1'b1;
    hsIf.idRs       = TB_REG_W'(8);
    hsIf.idUsesRs   = 1'b1;
    hsIf.idRegWrite = 1'b1;
    hsIf.idRd       = TB_REG_W'(9);
    @(negedge clk);
    compareValue("preRstPcWrite", int'(hsIf.pcWrite), 0);
    rst = 1'b0;
    #1;
    compareValue("midRstStallCount", int'(hsIf.stallCount), 0);
    compareValue("midRstForwardA",   int'(hsIf.forwardA),   0);
    compareValue("midRstPcWrite",    int'(hsIf.pcWrite),    1);
    modelReset();
    idleInputs();
    #1 rst = 1'b1;
    @(posedge clk);
    modelStep();
    #1;

    $display("[TB] counter saturation");
    for (int i = 0; i < (1 << TB_CNT_W) + 5; i++) begin
      doLoad(8);
      doAlu(9, 8, 3, 0, 0);
      doAlu(9, 8, 3, 0, 0);
    end
    compareValue("satStallCount", int'(hsIf.stallCount), CNT_MAX);
    doNop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
